qtc_to_signmag: RTL

//  Converts a full-width two's-complement value back to qpoint sign-magnitude Q format.
//  It is the inverse of the magnitude-to-two's-complement path.
//  - Typical input: the 2N-bit product of a two's-complement multiply (2Q fraction bits).
//  - Output: an N-bit sign-magnitude word with Q fraction bits, rounded and saturated.
//  - Two-stage pipeline with valid/ready handshakes on both sides; sits between the

---
 rtl/qtc_to_signmag.sv | 88 ++++++++
 1 files changed

// File: rtl/qtc_to_signmag.sv
// qtc_to_signmag: converts a 2N-bit two's-complement value with 2Q fraction
// bits into an N-bit sign-magnitude word with Q fraction bits. The magnitude is
// rounded half away from zero and saturated. Two-stage pipeline.
//
// Handshake (valid/ready, both sides): a transfer happens on a rising edge
// where valid && ready. A producer holding valid keeps its data stable until
// the transfer. ready never depends combinationally on the same side's valid;
// o_ready depends only on pipeline occupancy and i_ready. While
// o_valid && !i_ready, o_result and o_ovf hold their values.
module qtc_to_signmag #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [2*N-1:0] i_data,
  input  logic           i_valid,
  output logic           o_ready,
  output logic [N-1:0]   o_result,
  output logic           o_ovf,
  output logic           o_valid,
  input  logic           i_ready
);

  localparam int W = 2 * N;
  // Largest magnitude an N-bit sign-magnitude word can carry, at t's width.
  localparam logic [W:0] MAG_MAX = (W + 1)'({(N - 1){1'b1}});

  logic           s1_valid;
  logic           s1_sign;
  logic [W-1:0]   s1_mag;
  logic [W-1:0]   s1_mag_next;

  logic           s1_en;
  logic           s2_en;

  logic [W:0]     t;
  logic           sat;
  logic [N-2:0]   mag_next;
  logic           sign_next;

  // Stage enables: a stage advances when its output slot is empty or drains.
  always_comb begin
    s2_en   = !o_valid | i_ready;
    s1_en   = !s1_valid | s2_en;
    o_ready = s1_en;
  end

  // Absolute value of the input; the most-negative input maps to 2^(W-1),
  // which still fits as a W-bit unsigned value.
  always_comb begin
    s1_mag_next = i_data[W-1] ? ((~i_data) + W'(1)) : i_data;
  end

  // Stage 1 register: sign and magnitude of the accepted input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= i_valid;
      s1_sign  <= i_data[W-1];
      s1_mag   <= s1_mag_next;
    end
  end

  // Rescale by Q with round-half-away-from-zero, then saturate; t is one bit
  // wider than the magnitude so the rounding carry is never lost.
  always_comb begin
    t         = {1'b0, (s1_mag >> Q)} + (W + 1)'(s1_mag[Q-1]);
    sat       = (t > MAG_MAX);
    mag_next  = sat ? {(N - 1){1'b1}} : t[N-2:0];
    sign_next = s1_sign & (mag_next != '0);
  end

  // Stage 2 register: the visible result, held while downstream stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_ovf    <= 1'b0;
    end else if (s2_en) begin
      o_valid  <= s1_valid;
      o_result <= {sign_next, mag_next};
      o_ovf    <= sat;
    end
  end

endmodule
